// File: rtl/sram_ctrl.sv
// Single-outstanding-request controller for an external asynchronous 1M x 16 SRAM.
// Strobes, address and response are registered; the FSM owns the tri-state data bus.
module sram_ctrl #(
    parameter int ADDR_W  = 20,
    parameter int DATA_W  = 16,
    parameter int RD_WAIT = 3,
    parameter int WR_WAIT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [1:0]        req_be,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic [ADDR_W-1:0] sram_addr,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n,
    output logic              sram_ub_n,
    output logic              sram_lb_n,
    inout  wire  [DATA_W-1:0] sram_data
);

    localparam int HALF  = DATA_W / 2;
    localparam int MAXW  = (RD_WAIT > WR_WAIT) ? RD_WAIT : WR_WAIT;
    localparam int CNT_W = (MAXW > 1) ? $clog2(MAXW) : 1;
    localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(RD_WAIT - 1);
    localparam logic [CNT_W-1:0] WR_LAST = CNT_W'(WR_WAIT - 1);

    typedef enum logic [2:0] {IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD, DONE} state_t;

    state_t              state, state_nx;
    logic [CNT_W-1:0]    cnt;
    logic [DATA_W-1:0]   wdata_q;
    logic [1:0]          be_q;
    logic                drive;
    logic                accept;
    logic [1:0]          be_nx;
    logic                ce_nx, oe_nx, we_nx, ub_nx, lb_nx, drive_nx;
    logic [DATA_W-1:0]   rd_masked;

    assign req_ready = (state == IDLE);
    assign accept    = req_valid && req_ready;
    assign sram_data = drive ? wdata_q : {DATA_W{1'bz}};

    // Disabled byte lanes read back as zero so stale bus bits never leak into the response.
    assign rd_masked = {be_q[1] ? sram_data[DATA_W-1:HALF] : {(DATA_W-HALF){1'b0}},
                        be_q[0] ? sram_data[HALF-1:0]      : {HALF{1'b0}}};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            wdata_q    <= '0;
            be_q       <= '0;
            drive      <= 1'b0;
            sram_addr  <= '0;
            sram_ce_n  <= 1'b1;
            sram_oe_n  <= 1'b1;
            sram_we_n  <= 1'b1;
            sram_ub_n  <= 1'b1;
            sram_lb_n  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
        end else begin
            state <= state_nx;
            if (state_nx != state)
                cnt <= '0;
            else if (state == RD || state == WR_PULSE)
                cnt <= cnt + 1'b1;
            if (accept) begin
                sram_addr <= req_addr;
                wdata_q   <= req_wdata;
                be_q      <= req_be;
            end
            drive      <= drive_nx;
            sram_ce_n  <= ce_nx;
            sram_oe_n  <= oe_nx;
            sram_we_n  <= we_nx;
            sram_ub_n  <= ub_nx;
            sram_lb_n  <= lb_nx;
            resp_valid <= (state_nx == DONE);
            if (state == RD && state_nx == DONE)
                resp_rdata <= rd_masked;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:     if (accept) state_nx = req_we ? WR_SETUP : RD;
            RD:       if (cnt == RD_LAST) state_nx = DONE;
            WR_SETUP: state_nx = WR_PULSE;
            WR_PULSE: if (cnt == WR_LAST) state_nx = WR_HOLD;
            WR_HOLD:  state_nx = DONE;
            DONE:     state_nx = IDLE;
            default:  state_nx = IDLE;
        endcase
    end

    // Outputs are decoded from the next state and registered, so pins line up with the state.
    always_comb begin
        be_nx    = (state == IDLE) ? req_be : be_q;
        ce_nx    = 1'b1;
        oe_nx    = 1'b1;
        we_nx    = 1'b1;
        ub_nx    = 1'b1;
        lb_nx    = 1'b1;
        drive_nx = 1'b0;
        case (state_nx)
            RD: begin
                ce_nx = 1'b0;
                oe_nx = 1'b0;
                ub_nx = ~be_nx[1];
                lb_nx = ~be_nx[0];
            end
            WR_SETUP, WR_HOLD: begin
                ce_nx    = 1'b0;
                ub_nx    = ~be_nx[1];
                lb_nx    = ~be_nx[0];
                drive_nx = 1'b1;
            end
            WR_PULSE: begin
                ce_nx    = 1'b0;
                we_nx    = 1'b0;
                ub_nx    = ~be_nx[1];
                lb_nx    = ~be_nx[0];
                drive_nx = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_sram_ctrl.sv
// Directed bench for sram_ctrl with a behavioural 1M x 16 async SRAM on the pins.
// Also watches the bus continuously for strobe overlap and contention.
module tb_sram_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [19:0] req_addr = '0;
    logic [15:0] req_wdata = '0;
    logic [1:0]  req_be = '0;
    logic        resp_valid;
    logic [15:0] resp_rdata;
    logic [19:0] sram_addr;
    logic        sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n;
    wire  [15:0] sram_data;

    int n_checks = 0;
    int n_fail   = 0;
    int viol     = 0;

    logic [15:0] mem [0:1048575];

    sram_ctrl #(.ADDR_W(20), .DATA_W(16), .RD_WAIT(3), .WR_WAIT(2)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .sram_addr(sram_addr), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n),
        .sram_we_n(sram_we_n), .sram_ub_n(sram_ub_n), .sram_lb_n(sram_lb_n),
        .sram_data(sram_data)
    );

    always #5 clk = ~clk;

    // SRAM model: drives the bus while output-enabled, stores enabled lanes mid-pulse.
    assign sram_data = (!sram_ce_n && !sram_oe_n && sram_we_n) ? mem[sram_addr] : 16'hzzzz;

    always @(negedge clk) begin
        if (!sram_ce_n && !sram_we_n) begin
            if (!sram_ub_n) mem[sram_addr][15:8] <= sram_data[15:8];
            if (!sram_lb_n) mem[sram_addr][7:0]  <= sram_data[7:0];
        end
        if (!sram_oe_n && !sram_we_n) viol++;
        if (!sram_oe_n && dut.drive) viol++;
        if (!sram_we_n && $isunknown(sram_data)) viol++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_req(input logic we, input logic [19:0] addr, input logic [15:0] wdata,
                          input logic [1:0] be, output logic [15:0] rdata, output int lat);
        @(negedge clk);
        check("ready before request", req_ready, 1'b1);
        req_we = we; req_addr = addr; req_wdata = wdata; req_be = be; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 0;
        rdata = '0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (resp_valid) begin
                lat = n;
                rdata = resp_rdata;
                check("ready low in DONE", req_ready, 1'b0);
                break;
            end
        end
        @(negedge clk);
        check("resp single pulse", resp_valid, 1'b0);
    endtask

    logic [15:0] rd, exp_rd;
    int          lat, k, t_prev, nresp;
    logic        we_prev;

    initial begin
        // 1: reset state, then reset in the middle of a read
        #12;
        check("rst ce_n", sram_ce_n, 1'b1);
        check("rst oe_n", sram_oe_n, 1'b1);
        check("rst we_n", sram_we_n, 1'b1);
        check("rst ub/lb", {sram_ub_n, sram_lb_n}, 2'b11);
        check("rst addr", sram_addr, 20'h0);
        check("rst rdata", resp_rdata, 16'h0);
        check("rst resp", resp_valid, 1'b0);
        check("rst bus released", dut.drive, 1'b0);
        @(negedge clk) rst = 1'b0;
        @(negedge clk);
        check("ready after reset", req_ready, 1'b1);

        req_we = 1'b0; req_addr = 20'h00010; req_be = 2'b11; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        #2 check("mid-read oe_n low", sram_oe_n, 1'b0);
        rst = 1'b1;
        #1;
        check("async rst strobes", {sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n}, 5'b11111);
        check("async rst bus", dut.drive, 1'b0);
        @(negedge clk) rst = 1'b0;
        check("ready after mid reset", req_ready, 1'b1);
        nresp = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (resp_valid) nresp++;
        end
        check("no resp after aborted read", nresp, 0);

        // 2: write then read back
        do_req(1'b1, 20'h00010, 16'hBEEF, 2'b11, rd, lat);
        check("write latency", lat, 5);
        do_req(1'b0, 20'h00010, 16'h0000, 2'b11, rd, lat);
        check("read latency", lat, 4);
        check("read BEEF", rd, 16'hBEEF);

        // 3: byte lanes
        do_req(1'b1, 20'h0ABCD, 16'h1234, 2'b11, rd, lat);
        do_req(1'b1, 20'h0ABCD, 16'hFF00, 2'b10, rd, lat);
        do_req(1'b1, 20'h0ABCD, 16'h0056, 2'b01, rd, lat);
        do_req(1'b0, 20'h0ABCD, 16'h0000, 2'b11, rd, lat);
        check("merged lanes", rd, 16'hFF56);
        do_req(1'b0, 20'h0ABCD, 16'h0000, 2'b10, rd, lat);
        check("upper-only read", rd, 16'hFF00);
        do_req(1'b0, 20'h0ABCD, 16'h0000, 2'b01, rd, lat);
        check("lower-only read", rd, 16'h0056);

        // 4: back-to-back with req_valid held, alternating write/read at top address
        k = 0; t_prev = 0; nresp = 0; we_prev = 1'b0; exp_rd = '0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (resp_valid) begin
                nresp++;
                if (!we_prev) check("b2b rdata", resp_rdata, exp_rd);
            end
            if (req_ready) begin
                if (k > 0) check("b2b accept gap", i - t_prev, we_prev ? 6 : 5);
                if (k == 4) begin
                    req_valid = 1'b0;
                    break;
                end
                we_prev   = (k % 2 == 0);
                req_we    = we_prev;
                req_addr  = 20'hFFFFF;
                req_be    = 2'b11;
                req_wdata = (k == 0) ? 16'hA5A5 : 16'h5A5A;
                if (we_prev) exp_rd = req_wdata;
                req_valid = 1'b1;
                t_prev    = i;
                k++;
            end
        end
        req_valid = 1'b0;
        check("b2b accepts", k, 4);
        check("b2b responses", nresp, 4);

        // 5: reset during the write pulse
        do_req(1'b1, 20'h00100, 16'h5555, 2'b11, rd, lat);
        @(negedge clk);
        req_we = 1'b1; req_addr = 20'h00100; req_wdata = 16'hAAAA; req_be = 2'b11; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        check("setup we_n high", sram_we_n, 1'b1);
        @(negedge clk);
        check("pulse we_n low", sram_we_n, 1'b0);
        #2 rst = 1'b1;
        #1;
        check("rst pulse we_n", sram_we_n, 1'b1);
        check("rst pulse ce_n", sram_ce_n, 1'b1);
        check("rst pulse bus", dut.drive, 1'b0);
        check("rst pulse resp", resp_valid, 1'b0);
        @(negedge clk) rst = 1'b0;
        do_req(1'b0, 20'h00100, 16'h0000, 2'b11, rd, lat);
        check("aborted write data", (rd === 16'h5555 || rd === 16'hAAAA), 1'b1);

        // 6: be=00 write leaves memory untouched but still responds
        do_req(1'b1, 20'h00200, 16'h1357, 2'b11, rd, lat);
        do_req(1'b1, 20'h00200, 16'h0000, 2'b00, rd, lat);
        check("be00 write latency", lat, 5);
        do_req(1'b0, 20'h00200, 16'h0000, 2'b11, rd, lat);
        check("be00 preserved", rd, 16'h1357);

        check("bus protocol violations", viol, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
